// File: rtl/riscv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 encodings,
// FSM states, datapath width and a conditional two's-complement helper.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  // Returns -v when n is set, v otherwise.
  function automatic logic [XLEN_DEF-1:0] cond_neg(input logic [XLEN_DEF-1:0] v,
                                                   input logic                n);
    return n ? (0 - v) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider, one quotient bit per step. quo_o/rem_o present the
// values that the current step produces, so the caller can capture the final
// result on the same edge as the last iteration.
module div_core
  import riscv_pkg::*;
#(
  parameter int W = XLEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         last_o,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rem_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          fits;

  // The dividend is shifted out of quo_q's MSB while quotient bits enter at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = ~diff[W];
    rem_d   = fits ? diff[W-1:0] : shifted[W-1:0];
    quo_d   = {quo_q[W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign last_o = (cnt_q == CW'(W - 1));
  assign quo_o  = quo_d;
  assign rem_o  = rem_d;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: single-cycle multiply and divide
// special cases, 32-iteration restoring divide, pipeline stall and flush control.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall,
  output logic [1:0]      dbg_state
);

  muldiv_state_e state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            qneg_q, rneg_q, rem_sel_q;

  logic                   is_mul, is_sdiv, is_rem, div_zero, overflow, single;
  logic                   a_sx, b_sx;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic signed [2*XLEN+1:0] prod;
  logic [XLEN-1:0]        mul_res, special_res, single_res, a_mag, b_mag, final_res;
  logic                   core_load, core_step, core_last;
  logic [XLEN-1:0]        core_quo, core_rem;

  // Operand classification for the op sampled in IDLE.
  always_comb begin
    is_mul   = ~op[2];
    is_sdiv  = op[2] & ~op[0];
    is_rem   = op[1];
    div_zero = (b == '0);
    overflow = is_sdiv & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    single   = is_mul | div_zero | overflow;
  end

  // One signed 33x33 multiplier; the extension bit selects signed vs unsigned operands.
  always_comb begin
    a_sx    = (op != OP_MULHU) & a[XLEN-1];
    b_sx    = ((op == OP_MUL) | (op == OP_MULH)) & b[XLEN-1];
    mul_a   = $signed({a_sx, a});
    mul_b   = $signed({b_sx, b});
    prod    = mul_a * mul_b;
    mul_res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    if (is_rem) special_res = div_zero ? a : '0;
    else        special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    single_res = is_mul ? mul_res : special_res;
    a_mag      = cond_neg(a, is_sdiv & a[XLEN-1]);
    b_mag      = cond_neg(b, is_sdiv & b[XLEN-1]);
    final_res  = rem_sel_q ? cond_neg(core_rem, rneg_q) : cond_neg(core_quo, qneg_q);
  end

  div_core #(.W(XLEN)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (core_load),
    .step_i     (core_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .last_o     (core_last),
    .quo_o      (core_quo),
    .rem_o      (core_rem)
  );

  // Flush wins over start in every state; result only moves on entry to DONE.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (single) begin
            state_d  = S_DONE;
            result_d = single_res;
          end else begin
            state_d   = S_DIV;
            core_load = 1'b1;
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) begin
            state_d  = S_DONE;
            result_d = final_res;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (core_load) begin
        qneg_q    <= is_sdiv & (a[XLEN-1] ^ b[XLEN-1]);
        rneg_q    <= is_sdiv & a[XLEN-1];
        rem_sel_q <= is_rem;
      end
    end
  end

  assign result    = result_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign stall     = ~rst & (((state_q == S_IDLE) & start & ~flush) | (state_q == S_DIV));
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic        done, busy, stall;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .result(result), .done(done), .busy(busy), .stall(stall), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic following the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    int sx, sy;
    longint p;
    longint unsigned pu;
    logic [31:0] r;
    sx = x;
    sy = y;
    r  = '0;
    case (o)
      3'd0: begin p = longint'(sx) * longint'(sy); r = p[31:0]; end
      3'd1: begin p = longint'(sx) * longint'(sy); r = p[63:32]; end
      3'd2: begin p = longint'(sx) * longint'({32'd0, y}); r = p[63:32]; end
      3'd3: begin pu = {32'd0, x} * {32'd0, y}; r = pu[63:32]; end
      3'd4: r = (y == 0) ? 32'hFFFFFFFF :
                (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sx / sy);
      3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: r = (y == 0) ? x :
                (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'd0 : 32'(sx % sy);
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
    if (o < 3'd4 || y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Driver: issue in the current (IDLE) cycle, watch stall each cycle, check done latency.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] expv, input int lat);
    int cyc;
    exp_q.push_back(expv);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check({tag, "_stall_T"}, 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;
    #1;
    cyc = 1;
    while (!done && cyc < 40) begin
      check({tag, "_stall_busy"}, 32'(stall), 32'd1);
      tick();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done_at_%0d", tag, lat);
      void'(exp_q.pop_front());
    end else begin
      check({tag, "_latency"}, 32'(cyc), 32'(lat));
      check({tag, "_result"}, result, exp_q.pop_front());
      check({tag, "_stall_done"}, 32'(stall), 32'd0);
    end
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    last_result = expv;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel;

    rst = 1'b1; start = 1'b1; flush = 1'b0; op = 3'd0; a = 32'd3; b = 32'd4;
    #1;
    check("stall_in_reset", 32'(stall), 32'd0);
    tick(); tick();
    check("rst_result", result, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    start = 1'b0; rst = 1'b0;
    tick();
    last_result = 32'd0;

    run_op("mul",      3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1);
    run_op("div",      3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",      3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33);
    run_op("divu_z",   3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_z",   3'd7, 32'd5,          32'd0,        32'd5,        1);
    run_op("div_ovf",  3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",  3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1);
    run_op("mulhu",    3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    run_op("mulhsu",   3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 1);
    run_op("mulh",     3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 1);
    run_op("divu_max", 3'd5, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 33);

    // Flush during an iterative divide at T+10.
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      check("flush_no_early_done", 32'(done), 32'd0);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_state", 32'(dbg_state), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result_held", result, last_result);
    run_op("divu_after_flush", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    // Reset at T+5 of a signed divide.
    start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    tick();
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    rst = 1'b0;
    last_result = 32'd0;
    tick();
    check("rst_mid_no_done", 32'(done), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      run_op("rand", ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
